can_tx_sched: RTL and testbench

//  Transmit-mailbox scheduler for the CAN 2.0B core. It holds NUM_MB host-loaded frames and

---
 rtl/can_tx_sched_if.sv | 45 ++++
 rtl/can_tx_sched.sv | 235 +++++++++++++++++++++++
 tb/tb_can_tx_sched.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/can_tx_sched_if.sv
// Signal bundle between the host register block, can_tx_sched and the CAN TX bit engine.
// slave = scheduler side, master = host/engine side.
interface can_tx_sched_if #(
  parameter int unsigned NUM_MB = 4
);
  localparam int unsigned IDXW = $clog2(NUM_MB);

  logic              wr_en;
  logic [IDXW-1:0]   wr_idx;
  logic [28:0]       wr_id;
  logic              wr_ide;
  logic              wr_rtr;
  logic [3:0]        wr_dlc;
  logic [63:0]       wr_data;
  logic              wr_reject;
  logic [NUM_MB-1:0] abort_req;
  logic [NUM_MB-1:0] mb_pending;
  logic [NUM_MB-1:0] mb_done;
  logic [NUM_MB-1:0] mb_aborted;
  logic [NUM_MB-1:0] mb_fail;
  logic              bus_idle;
  logic              tx_start;
  logic [28:0]       tx_id;
  logic              tx_ide;
  logic              tx_rtr;
  logic [3:0]        tx_dlc;
  logic [63:0]       tx_data;
  logic              tx_done;
  logic              tx_arb_lost;
  logic              tx_error;

  modport slave (
    input  wr_en, wr_idx, wr_id, wr_ide, wr_rtr, wr_dlc, wr_data, abort_req, bus_idle,
    input  tx_done, tx_arb_lost, tx_error,
    output wr_reject, mb_pending, mb_done, mb_aborted, mb_fail,
    output tx_start, tx_id, tx_ide, tx_rtr, tx_dlc, tx_data
  );

  modport master (
    output wr_en, wr_idx, wr_id, wr_ide, wr_rtr, wr_dlc, wr_data, abort_req, bus_idle,
    output tx_done, tx_arb_lost, tx_error,
    input  wr_reject, mb_pending, mb_done, mb_aborted, mb_fail,
    input  tx_start, tx_id, tx_ide, tx_rtr, tx_dlc, tx_data
  );
endinterface

// File: rtl/can_tx_sched.sv
// CAN 2.0B transmit-mailbox scheduler: offers the highest-priority pending frame to the TX engine.
// Optional retry limit enabled by defining CAN_TX_RETRY_LIMIT_EN.
module can_tx_sched #(
  parameter int unsigned NUM_MB    = 4,
  parameter int unsigned MAX_RETRY = 8
) (
  input logic           clk,
  input logic           rst_n,
  can_tx_sched_if.slave bus
);
  localparam int unsigned IDXW = $clog2(NUM_MB);

  typedef enum logic [1:0] {StIdle, StSelect, StStart, StActive} state_e;
  state_e state_q, state_d;

  logic [28:0] mb_id_q   [NUM_MB];
  logic        mb_ide_q  [NUM_MB];
  logic        mb_rtr_q  [NUM_MB];
  logic [3:0]  mb_dlc_q  [NUM_MB];
  logic [63:0] mb_data_q [NUM_MB];
  logic [31:0] key       [NUM_MB];

  logic [NUM_MB-1:0] pending_q, pending_d;
  logic [NUM_MB-1:0] done_q, done_d, aborted_q, aborted_d;
  logic [NUM_MB-1:0] wr_hit, wr_accept, abort_now, inflight, pend_avail;
  logic              reject_q, reject_d;
  logic              abort_lat_q, abort_lat_d, abort_eff;
  logic [IDXW-1:0]   sel_q, win_idx;
  logic              win_valid;
  logic [31:0]       best_key;
  logic [28:0]       tx_id_q;
  logic              tx_ide_q, tx_rtr_q;
  logic [3:0]        tx_dlc_q;
  logic [63:0]       tx_data_q;

`ifdef CAN_TX_RETRY_LIMIT_EN
  logic [3:0]        retry_q [NUM_MB];
  logic [3:0]        retry_d [NUM_MB];
  logic [NUM_MB-1:0] fail_q, fail_d;
`endif

  // Lower key wins; a standard frame beats an extended one with the same 11-bit base.
  function automatic logic [31:0] prio_key(input logic [28:0] id, input logic ide,
                                           input logic rtr);
    if (ide) return {id[28:18], 1'b1, 1'b1, id[17:0], rtr};
    return {id[10:0], rtr, 1'b0, 19'b0};
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_MB; i++) key[i] = prio_key(mb_id_q[i], mb_ide_q[i], mb_rtr_q[i]);
  end

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    win_idx   = '0;
    win_valid = 1'b0;
    best_key  = '1;
    for (int i = 0; i < NUM_MB; i++) begin
      if (pending_q[i] && (!win_valid || key[i] < best_key)) begin
        win_valid = 1'b1;
        win_idx   = IDXW'(i);
        best_key  = key[i];
      end
    end
  end

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (bus.wr_en && bus.wr_idx == IDXW'(i)) wr_hit[i] = 1'b1;
    end
  end

  always_comb begin
    inflight = '0;
    if (state_q == StSelect && win_valid) inflight[win_idx] = 1'b1;
    else if (state_q == StStart || state_q == StActive) inflight[sel_q] = 1'b1;
  end

  assign wr_accept  = wr_hit & ~pending_q & ~bus.abort_req;
  assign reject_d   = |(wr_hit & pending_q & ~bus.abort_req);
  assign abort_now  = bus.abort_req & pending_q & ~inflight;
  assign pend_avail = (pending_q & ~bus.abort_req) | wr_accept;
  assign abort_eff  = abort_lat_q | (|(bus.abort_req & inflight));

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (bus.bus_idle && (|pend_avail)) state_d = StSelect;
      StSelect: state_d = win_valid ? StStart : StIdle;
      StStart:  state_d = StActive;
      StActive: if (bus.tx_done || bus.tx_arb_lost || bus.tx_error) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // An abort hitting the frame on the wire is held until the attempt's outcome is known.
  always_comb begin
    abort_lat_d = 1'b0;
    if (state_q == StSelect) begin
      abort_lat_d = |(bus.abort_req & inflight);
    end else if (state_q == StStart || (state_q == StActive && state_d == StActive)) begin
      abort_lat_d = abort_eff;
    end
  end

  always_comb begin
    pending_d = (pending_q | wr_accept) & ~abort_now;
    done_d    = '0;
    aborted_d = abort_now;
`ifdef CAN_TX_RETRY_LIMIT_EN
    fail_d  = '0;
    retry_d = retry_q;
    for (int i = 0; i < NUM_MB; i++) begin
      if (wr_accept[i] || abort_now[i]) retry_d[i] = '0;
    end
`endif
    if (state_q == StActive) begin
      if (bus.tx_done) begin
        pending_d[sel_q] = 1'b0;
        done_d[sel_q]    = 1'b1;
`ifdef CAN_TX_RETRY_LIMIT_EN
        retry_d[sel_q]   = '0;
`endif
      end else if (bus.tx_arb_lost || bus.tx_error) begin
        if (abort_eff) begin
          pending_d[sel_q] = 1'b0;
          aborted_d[sel_q] = 1'b1;
`ifdef CAN_TX_RETRY_LIMIT_EN
          retry_d[sel_q]   = '0;
        end else if (bus.tx_error) begin
          if ((32'(retry_q[sel_q]) + 32'd1) == MAX_RETRY) begin
            pending_d[sel_q] = 1'b0;
            fail_d[sel_q]    = 1'b1;
            retry_d[sel_q]   = '0;
          end else if (retry_q[sel_q] != 4'hF) begin
            retry_d[sel_q] = retry_q[sel_q] + 4'd1;
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      done_q      <= '0;
      aborted_q   <= '0;
      reject_q    <= 1'b0;
      abort_lat_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      reject_q    <= reject_d;
      abort_lat_q <= abort_lat_d;
    end
  end

`ifdef CAN_TX_RETRY_LIMIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_q <= '0;
      for (int i = 0; i < NUM_MB; i++) retry_q[i] <= '0;
    end else begin
      fail_q  <= fail_d;
      retry_q <= retry_d;
    end
  end
  assign bus.mb_fail = fail_q;
`else
  logic unused_max_retry;
  assign unused_max_retry = (MAX_RETRY == 0);
  assign bus.mb_fail      = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_MB; i++) begin
        mb_id_q[i]   <= '0;
        mb_ide_q[i]  <= 1'b0;
        mb_rtr_q[i]  <= 1'b0;
        mb_dlc_q[i]  <= '0;
        mb_data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_MB; i++) begin
        if (wr_accept[i]) begin
          mb_id_q[i]   <= bus.wr_id;
          mb_ide_q[i]  <= bus.wr_ide;
          mb_rtr_q[i]  <= bus.wr_rtr;
          mb_dlc_q[i]  <= bus.wr_dlc;
          mb_data_q[i] <= bus.wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= '0;
      tx_id_q   <= '0;
      tx_ide_q  <= 1'b0;
      tx_rtr_q  <= 1'b0;
      tx_dlc_q  <= '0;
      tx_data_q <= '0;
    end else if (state_q == StSelect && win_valid) begin
      sel_q     <= win_idx;
      tx_id_q   <= mb_id_q[win_idx];
      tx_ide_q  <= mb_ide_q[win_idx];
      tx_rtr_q  <= mb_rtr_q[win_idx];
      tx_dlc_q  <= mb_dlc_q[win_idx];
      tx_data_q <= mb_data_q[win_idx];
    end
  end

  // FSM outputs
  always_comb begin
    bus.tx_start = (state_q == StStart);
  end

  assign bus.wr_reject  = reject_q;
  assign bus.mb_pending = pending_q;
  assign bus.mb_done    = done_q;
  assign bus.mb_aborted = aborted_q;
  assign bus.tx_id      = tx_id_q;
  assign bus.tx_ide     = tx_ide_q;
  assign bus.tx_rtr     = tx_rtr_q;
  assign bus.tx_dlc     = tx_dlc_q;
  assign bus.tx_data    = tx_data_q;
endmodule

// File: tb/tb_can_tx_sched.sv
// Directed bench for can_tx_sched: priority order, retries, aborts, write rejects, reset.
// Expects MAX_RETRY=3; honours CAN_TX_RETRY_LIMIT_EN when defined.
module tb_can_tx_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  can_tx_sched_if #(.NUM_MB(4)) bus ();

  can_tx_sched #(.NUM_MB(4), .MAX_RETRY(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] idx, input logic [28:0] id, input logic ide,
                    input logic [3:0] dlc, input logic [63:0] data);
    bus.wr_idx  = idx;
    bus.wr_id   = id;
    bus.wr_ide  = ide;
    bus.wr_rtr  = 1'b0;
    bus.wr_dlc  = dlc;
    bus.wr_data = data;
    bus.wr_en   = 1'b1;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic expect_start(input string tag, input logic [28:0] id, input logic ide);
    int n = 0;
    while (bus.tx_start !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    chk({tag, " tx_start"}, 64'(bus.tx_start), 64'd1);
    chk({tag, " tx_id"}, 64'(bus.tx_id), 64'(id));
    chk({tag, " tx_ide"}, 64'(bus.tx_ide), 64'(ide));
  endtask

  // Called in START; completes the frame and checks the done pulse.
  task automatic done_frame(input string tag, input logic [3:0] mb);
    tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    chk({tag, " mb_done"}, 64'(bus.mb_done), 64'(mb));
    chk({tag, " cleared"}, 64'(bus.mb_pending & mb), 64'd0);
  endtask

  initial begin
    bus.wr_en = 0; bus.wr_idx = 0; bus.wr_id = 0; bus.wr_ide = 0; bus.wr_rtr = 0;
    bus.wr_dlc = 0; bus.wr_data = 0; bus.abort_req = 0; bus.bus_idle = 0;
    bus.tx_done = 0; bus.tx_arb_lost = 0; bus.tx_error = 0;

    // Reset state
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rst pending", 64'(bus.mb_pending), 64'd0);
    chk("rst tx_start", 64'(bus.tx_start), 64'd0);
    chk("rst pulses", 64'({bus.mb_done, bus.mb_aborted, bus.mb_fail, bus.wr_reject}), 64'd0);
    chk("rst tx_id", 64'(bus.tx_id), 64'd0);

    // 1: single frame, two-cycle latency
    bus.bus_idle = 1'b1;
    wr(2'd0, 29'h123, 1'b0, 4'd2, 64'hA55A);
    chk("t1 pending", 64'(bus.mb_pending), 64'h1);
    chk("t1 no early start", 64'(bus.tx_start), 64'd0);
    tick();
    chk("t1 tx_start", 64'(bus.tx_start), 64'd1);
    chk("t1 tx_id", 64'(bus.tx_id), 64'h123);
    chk("t1 tx_dlc", 64'(bus.tx_dlc), 64'd2);
    chk("t1 tx_data", bus.tx_data, 64'hA55A);
    done_frame("t1", 4'b0001);
    tick();
    chk("t1 done 1 cycle", 64'(bus.mb_done), 64'd0);

    // 2: priority order MB1 (std 0x100), MB2 (ext same base), MB0 (0x200)
    bus.bus_idle = 1'b0;
    wr(2'd0, 29'h200, 1'b0, 4'd1, 64'h1);
    wr(2'd1, 29'h100, 1'b0, 4'd1, 64'h2);
    wr(2'd2, 29'h100 << 18, 1'b1, 4'd1, 64'h3);
    chk("t2 pending", 64'(bus.mb_pending), 64'h7);
    bus.bus_idle = 1'b1;
    expect_start("t2 first", 29'h100, 1'b0);
    done_frame("t2 first", 4'b0010);
    expect_start("t2 second", 29'h100 << 18, 1'b1);
    done_frame("t2 second", 4'b0100);
    expect_start("t2 third", 29'h200, 1'b0);
    done_frame("t2 third", 4'b0001);

    // 3: tie goes to lowest index; tx_done beats tx_error
    bus.bus_idle = 1'b0;
    wr(2'd3, 29'h050, 1'b0, 4'd0, 64'h0);
    wr(2'd1, 29'h050, 1'b0, 4'd0, 64'h0);
    bus.bus_idle = 1'b1;
    expect_start("t3 first", 29'h050, 1'b0);
    done_frame("t3 first", 4'b0010);
    expect_start("t3 second", 29'h050, 1'b0);
    tick();
    bus.tx_done = 1'b1; bus.tx_error = 1'b1;
    tick();
    bus.tx_done = 1'b0; bus.tx_error = 1'b0;
    chk("t3 done over error", 64'(bus.mb_done), 64'h8);
    chk("t3 pending", 64'(bus.mb_pending), 64'd0);

    // 4: arbitration loss, write reject, result ignored outside ACTIVE
    wr(2'd0, 29'h321, 1'b0, 4'd1, 64'h0);
    expect_start("t4", 29'h321, 1'b0);
    tick();
    bus.bus_idle = 1'b0; bus.tx_arb_lost = 1'b1;
    tick();
    bus.tx_arb_lost = 1'b0;
    chk("t4 no pulses", 64'({bus.mb_done, bus.mb_aborted}), 64'd0);
    chk("t4 pending kept", 64'(bus.mb_pending), 64'h1);
    wr(2'd0, 29'h7FF, 1'b0, 4'd1, 64'h0);
    chk("t4 wr_reject", 64'(bus.wr_reject), 64'd1);
    tick();
    chk("t4 wr_reject pulse", 64'(bus.wr_reject), 64'd0);
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    tick();
    chk("t4 stray done", 64'(bus.mb_done), 64'd0);
    chk("t4 no start busy bus", 64'(bus.tx_start), 64'd0);
    bus.bus_idle = 1'b1;
    expect_start("t4 retry", 29'h321, 1'b0);
    done_frame("t4 retry", 4'b0001);

    // 5: aborts
    bus.bus_idle = 1'b0;
    wr(2'd2, 29'h010, 1'b0, 4'd0, 64'h0);
    bus.abort_req = 4'b0100;
    tick();
    bus.abort_req = 4'b0000;
    chk("t5 idle abort", 64'(bus.mb_aborted), 64'h4);
    chk("t5 idle pending", 64'(bus.mb_pending), 64'd0);
    tick();
    chk("t5 abort 1 cycle", 64'(bus.mb_aborted), 64'd0);

    bus.bus_idle = 1'b1;
    wr(2'd0, 29'h011, 1'b0, 4'd0, 64'h0);
    expect_start("t5 err", 29'h011, 1'b0);
    bus.abort_req = 4'b0001;
    tick();
    bus.abort_req = 4'b0000;
    chk("t5 latched no pulse", 64'(bus.mb_aborted), 64'd0);
    chk("t5 latched pending", 64'(bus.mb_pending), 64'h1);
    bus.tx_error = 1'b1;
    tick();
    bus.tx_error = 1'b0;
    chk("t5 inflight abort", 64'(bus.mb_aborted), 64'h1);
    chk("t5 inflight pending", 64'(bus.mb_pending), 64'd0);

    wr(2'd0, 29'h012, 1'b0, 4'd0, 64'h0);
    expect_start("t5 done", 29'h012, 1'b0);
    tick();
    bus.abort_req = 4'b0001;
    tick();
    bus.abort_req = 4'b0000;
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    chk("t5 abort discarded done", 64'(bus.mb_done), 64'h1);
    chk("t5 abort discarded", 64'(bus.mb_aborted), 64'd0);

    bus.bus_idle = 1'b0;
    wr(2'd1, 29'h060, 1'b0, 4'd0, 64'h0);
    bus.wr_idx = 2'd1; bus.wr_en = 1'b1; bus.abort_req = 4'b0010;
    tick();
    bus.wr_en = 1'b0; bus.abort_req = 4'b0000;
    chk("t5 abort+wr no reject", 64'(bus.wr_reject), 64'd0);
    chk("t5 abort+wr aborted", 64'(bus.mb_aborted), 64'h2);
    chk("t5 abort+wr pending", 64'(bus.mb_pending), 64'd0);

    // 6: repeated bus errors on MB1
    bus.bus_idle = 1'b1;
    wr(2'd1, 29'h077, 1'b0, 4'd0, 64'h0);
    for (int k = 0; k < 3; k++) begin
      expect_start($sformatf("t6 try%0d", k), 29'h077, 1'b0);
      tick();
      bus.tx_error = 1'b1;
      tick();
      bus.tx_error = 1'b0;
`ifdef CAN_TX_RETRY_LIMIT_EN
      chk($sformatf("t6 fail%0d", k), 64'(bus.mb_fail), (k == 2) ? 64'h2 : 64'd0);
      chk($sformatf("t6 pend%0d", k), 64'(bus.mb_pending), (k == 2) ? 64'd0 : 64'h2);
`else
      chk($sformatf("t6 fail%0d", k), 64'(bus.mb_fail), 64'd0);
      chk($sformatf("t6 pend%0d", k), 64'(bus.mb_pending), 64'h2);
`endif
    end
`ifdef CAN_TX_RETRY_LIMIT_EN
    repeat (4) tick();
    chk("t6 no 4th start", 64'(bus.tx_start), 64'd0);
`else
    expect_start("t6 4th try", 29'h077, 1'b0);
    done_frame("t6 4th try", 4'b0010);
`endif

    // Reset in the middle of a frame
    wr(2'd2, 29'h005, 1'b0, 4'd0, 64'h0);
    expect_start("rst mid", 29'h005, 1'b0);
    tick();
    rst_n = 1'b0;
    #2;
    chk("rst mid pending", 64'(bus.mb_pending), 64'd0);
    chk("rst mid tx_id", 64'(bus.tx_id), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("rst mid no start", 64'(bus.tx_start), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
